// File: rtl/sqrt_iter_ctrl.sv
// sqrt_iter_ctrl -- iterative integer square root sequencer.
//
// The root is produced one bit per cycle by a single restoring root step,
// walking the radicand two bits at a time from the MSB pair down.
// There is one transaction in flight at a time.
// Accept-to-result latency is WIDTH cycles.
//
// Parameters:
//   WIDTH      root width in bits (>= 2); the radicand is 2*WIDTH bits.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active low
//   in_valid   radicand valid
//   in_ready   controller can accept a radicand
//   radicand   unsigned operand, sampled on the input handshake only
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   dout       floor(sqrt(radicand)), held until the next result
//   remainder  radicand - dout*dout, held until the next result
//   busy       high while the root steps are running
//
// Build option:
//   SQRT_ITER_CTRL_BYPASS_EN  When defined, a result handshake and a new
//   input handshake can happen on the same edge. The new radicand then goes
//   straight from DONE to CALC without passing through IDLE. This adds a
//   combinational out_ready -> in_ready path.

// One restoring root step. The step shifts the next radicand bit pair into
// the partial remainder. It then tries to subtract (root<<2)|1.
module sqrt_iter_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH+1:0] rem,
  input  logic [WIDTH-1:0] root,
  input  logic [1:0]       pair,
  output logic [WIDTH+1:0] rem_nxt,
  output logic [WIDTH-1:0] root_nxt
);
  // The compare is done at full width so that no intermediate value is lost.
  logic [WIDTH+3:0] r, t;
  logic [WIDTH+1:0] diff_lo;
  logic             ge;

  assign r = {rem, pair};
  assign t = {2'b00, root, 2'b01};
  assign ge = (r >= t);
  // When ge is set, the true difference is at most 2*root+... and fits in
  // WIDTH+2 bits, so a low-part subtraction is exact.
  assign diff_lo  = r[WIDTH+1:0] - t[WIDTH+1:0];
  assign rem_nxt  = ge ? diff_lo : r[WIDTH+1:0];
  assign root_nxt = {root[WIDTH-2:0], ge};
endmodule

module sqrt_iter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] radicand,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   dout,
  output logic [WIDTH:0]     remainder,
  output logic               busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] operand;
  logic [WIDTH-1:0]   root;
  logic [WIDTH+1:0]   rem;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [WIDTH+1:0]   rem_nxt;
  logic [WIDTH-1:0]   root_nxt;
  logic               accept;

  // The operand is shifted left by two bits each step, so the current bit
  // pair is always the top two bits. This avoids a counter-indexed mux.
  sqrt_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .root     (root),
    .pair     (operand[2*WIDTH-1:2*WIDTH-2]),
    .rem_nxt  (rem_nxt),
    .root_nxt (root_nxt)
  );

`ifdef SQRT_ITER_CTRL_BYPASS_EN
  // out_valid_q is high only in DONE, so this gives in_ready = out_ready there.
  assign in_ready = in_ready_q | (out_valid_q & out_ready);
`else
  assign in_ready = in_ready_q;
`endif
  assign out_valid = out_valid_q;
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      operand     <= '0;
      root        <= '0;
      rem         <= '0;
      dout        <= '0;
      remainder   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        CALC: begin
          operand <= {operand[2*WIDTH-3:0], 2'b00};
          root    <= root_nxt;
          rem     <= rem_nxt;
          if (cnt == '0) begin
            dout        <= root_nxt;
            remainder   <= rem_nxt[WIDTH:0];
            out_valid_q <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy        <= 1'b0;
        end
      endcase

      // A load overrides whatever the case statement above decided. It can
      // fire from IDLE, and from DONE when the bypass build is enabled.
      if (accept) begin
        operand    <= radicand;
        root       <= '0;
        rem        <= '0;
        cnt        <= CW'(WIDTH - 1);
        in_ready_q <= 1'b0;
        busy       <= 1'b1;
        state      <= CALC;
      end
    end
  end
endmodule

// File: tb/tb_sqrt_iter_ctrl.sv
module tb_sqrt_iter_ctrl;
  localparam int W = 4;
`ifdef SQRT_ITER_CTRL_BYPASS_EN
  localparam int SPACING = 5;
  localparam int OUT_TO_ACC = 0;
`else
  localparam int SPACING = 6;
  localparam int OUT_TO_ACC = 1;
`endif

  logic           clk, rst_n;
  logic           in_valid, in_ready;
  logic [2*W-1:0] radicand;
  logic           out_valid, out_ready;
  logic [W-1:0]   dout;
  logic [W:0]     remainder;
  logic           busy;

  int n_chk = 0;
  int n_fail = 0;

  sqrt_iter_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .radicand(radicand),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .remainder(remainder), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    int         stall;
    logic [3:0] exp_d;
    logic [4:0] exp_r;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Runs one transaction. The result is held for 'stall' cycles with
  // out_ready low, and a conflicting input is offered during the stall.
  task automatic do_txn(input logic [7:0] a, input int stall,
                        output logic [3:0] d, output logic [4:0] r);
    int n, lat, bz;
    radicand = a; in_valid = 1'b1; n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("accept_wait", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; radicand = ~a;
    lat = 0; bz = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bz++;
      chk("in_ready_calc", {31'd0, in_ready}, 0);
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, W);
    chk("busy_cycles", bz, W);
    chk("in_ready_done", {31'd0, in_ready}, 0);
    chk("busy_done", {31'd0, busy}, 0);
    d = dout; r = remainder;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1; radicand = a ^ 8'h5a;
      #1;
      chk("stall_in_ready", {31'd0, in_ready}, 0);
      @(posedge clk); #1;
      chk("stall_out_valid", {31'd0, out_valid}, 1);
      chk("stall_dout", {28'd0, dout}, {28'd0, d});
      chk("stall_rem", {27'd0, remainder}, {27'd0, r});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_out_valid", {31'd0, out_valid}, 0);
    chk("post_in_ready", {31'd0, in_ready}, 1);
    chk("post_busy", {31'd0, busy}, 0);
    chk("post_dout_hold", {28'd0, dout}, {28'd0, d});
  endtask

  function automatic int isqrt(input int a);
    int d = 0;
    for (int k = 0; k < 16; k++) if (k * k <= a) d = k;
    return d;
  endfunction

  initial begin
    vec_t       vecs[9];
    logic [3:0] d;
    logic [4:0] r;
    int         ac[2], oc[2], od[2], orr[2];
    int         na, no, cyc;
    logic       hi, ho;

    vecs[0] = '{8'd200, 0, 4'd14, 5'd4};
    vecs[1] = '{8'd0,   0, 4'd0,  5'd0};
    vecs[2] = '{8'd1,   1, 4'd1,  5'd0};
    vecs[3] = '{8'd255, 0, 4'd15, 5'd30};
    vecs[4] = '{8'd99, 10, 4'd9,  5'd18};
    vecs[5] = '{8'd144, 0, 4'd12, 5'd0};
    vecs[6] = '{8'd2,   2, 4'd1,  5'd1};
    vecs[7] = '{8'd15,  0, 4'd3,  5'd6};
    vecs[8] = '{8'd16,  3, 4'd4,  5'd0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; radicand = '0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_dout", {28'd0, dout}, 0);
    chk("rst_rem", {27'd0, remainder}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_txn(vecs[i].a, vecs[i].stall, d, r);
      chk($sformatf("vec%0d_dout", i), {28'd0, d}, {28'd0, vecs[i].exp_d});
      chk($sformatf("vec%0d_rem", i), {27'd0, r}, {27'd0, vecs[i].exp_r});
    end

    // Reset two cycles into the computation of 144.
    radicand = 8'd144; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", {31'd0, busy}, 1);
    rst_n = 1'b0; #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_dout", {28'd0, dout}, 0);
    chk("mid_rst_rem", {27'd0, remainder}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out_valid", {31'd0, out_valid}, 0);
    do_txn(8'd144, 0, d, r);
    chk("rerun144_dout", {28'd0, d}, 12);
    chk("rerun144_rem", {27'd0, r}, 0);

    // Sweep every radicand with random backpressure against a bench model.
    for (int a = 0; a < 256; a++) begin
      do_txn(a[7:0], int'($urandom_range(0, 2)), d, r);
      chk($sformatf("sweep%0d_dout", a), {28'd0, d}, isqrt(a));
      chk($sformatf("sweep%0d_identity", a), int'(d) * int'(d) + int'(r), a);
      chk($sformatf("sweep%0d_rembound", a), {31'd0, (int'(r) <= 2 * int'(d))}, 1);
    end

    // Back-to-back 49 then 50 with in_valid and out_ready held high.
    in_valid = 1'b1; radicand = 8'd49; out_ready = 1'b1;
    na = 0; no = 0; cyc = 0;
    for (int s = 0; s < 40 && no < 2; s++) begin
      hi = in_valid && in_ready;
      ho = out_valid && out_ready;
      if (ho) begin od[no] = int'(dout); orr[no] = int'(remainder); oc[no] = cyc; end
      if (hi && na < 2) ac[na] = cyc;
      @(posedge clk); #1; cyc++;
      if (ho) no++;
      if (hi) begin na++; radicand = 8'd50; if (na >= 2) in_valid = 1'b0; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_outputs", no, 2);
    chk("b2b_accepts", na, 2);
    if (no == 2 && na == 2) begin
      chk("b2b_d0", od[0], 7);
      chk("b2b_r0", orr[0], 0);
      chk("b2b_d1", od[1], 7);
      chk("b2b_r1", orr[1], 1);
      chk("b2b_spacing", ac[1] - ac[0], SPACING);
      chk("b2b_out_to_acc", ac[1] - oc[0], OUT_TO_ACC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
